// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
//   UART transmitter. Takes bytes from an on-chip producer over a valid/ready
//   handshake and serialises each one onto tx as an 8N1 / 8N2 frame, or as
//   8E1 / 8O1 (8E2 / 8O2) when parity is compiled in. Bit timing matches the
//   companion receiver (same CLK_FREQ / BAUD), so tx can loop straight back
//   into it.
//
// Build option
//   UART_TX_PARITY_EN  when defined, a parity bit is sent after data bit 7.
//                      PARITY_ODD selects the sense (0 = even, 1 = odd).
//                      When undefined, no parity bit is sent and PARITY_ODD
//                      has no effect.
//
// Parameters
//   CLK_FREQ    system clock, Hz
//   BAUD        line rate, bit/s (CLK_FREQ/BAUD must be >= 2)
//   STOP_BITS   1 or 2
//   PARITY_ODD  0 = even, 1 = odd (parity builds only)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active high
//   data[7:0]   in   byte to send, sampled on the accept cycle only
//   data_valid  in   producer has a byte on data
//   ready       out  block can take a byte; accept = data_valid && ready
//   tx          out  serial line, idle high, straight from a flop
//   busy        out  frame in progress (cycle after accept .. last stop cycle)
// -----------------------------------------------------------------------------
module uart_tx_stream #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  // Catch unusable configurations at elaboration rather than on the wire.
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_stream: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_stream: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // clocks within the current bit
  logic [2:0]       idx_q,   idx_d;    // data bit index, 0..7, holds at 7
  logic             stop_q,  stop_d;   // which stop bit (only moves for 2 stop bits)
  logic [7:0]       shreg_q, shreg_d;  // latched byte, shifted right per data bit
  logic             tx_q,    tx_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             bit_end;
  logic             accept;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic par_q, par_d;                  // parity of the latched byte
`endif

  assign accept  = data_valid && ready_q;
  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state logic. tx_d is the line level for the *next* cycle, so every
  // transition also decides the bit that goes out right after the edge; this
  // keeps tx a pure flop output with one cycle of latency from accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Baud counter free-runs inside a frame and reloads on every bit boundary.
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = S_START;
          shreg_d = data;
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = (^data) ^ PAR_SENSE;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // shreg_q[1] becomes shreg_d[0]: the next bit goes out now.
            idx_d   = idx_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Registered handshake/status: both follow the state we are entering,
    // which gives the single guaranteed IDLE cycle with ready=1 after a frame.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

  localparam int CPB       = 10;  // 1 MHz / 100 kbaud
  localparam int STOP_BITS = 1;
  localparam int PAR_ODD   = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int NBITS = 10 + NPAR + STOP_BITS - 1;
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       ready, tx, busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // model state
  int         fstart = -100000;
  logic [7:0] fbyte = 8'h00;
  logic       rst_prev = 1'b1;
  int         acc_cnt = 0;
  int         last_acc = 0;

  uart_tx_stream #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .STOP_BITS (STOP_BITS),
    .PARITY_ODD(PAR_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .data_valid(data_valid),
    .ready     (ready),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Line level of bit k of a frame carrying byte b.
  function automatic logic line_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NPAR == 1 && k == 9) return (^b) ^ (PAR_ODD != 0);
    return 1'b1;
  endfunction

  // Per-cycle model compare: a frame occupies cycles fstart+1 .. fstart+FRAME.
  task automatic monitor();
    logic etx, ebusy, erdy;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (rst_prev) begin
          etx = 1'b1; ebusy = 1'b0; erdy = 1'b0;
        end else if (cyc > fstart && cyc <= fstart + FRAME) begin
          etx = line_bit(fbyte, (cyc - fstart - 1) / CPB);
          ebusy = 1'b1; erdy = 1'b0;
        end else begin
          etx = 1'b1; ebusy = 1'b0; erdy = 1'b1;
        end
        chk("model_tx", {31'd0, tx}, {31'd0, etx});
        chk("model_busy", {31'd0, busy}, {31'd0, ebusy});
        chk("model_ready", {31'd0, ready}, {31'd0, erdy});
        if (rst) begin
          fstart = -100000;
        end else if (data_valid && erdy) begin
          fstart = cyc;
          fbyte = data;
          acc_cnt++;
          last_acc = cyc;
        end
        rst_prev = rst;
      end
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_acc(output int t);
    int n0;
    int k;
    n0 = acc_cnt;
    k = 0;
    while (acc_cnt == n0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("accept_seen", {31'd0, acc_cnt != n0}, 32'd1);
    t = last_acc;
  endtask

  task automatic send(input logic [7:0] b, output int t);
    data = b;
    data_valid = 1'b1;
    wait_acc(t);
    data_valid = 1'b0;
    data = 8'h00;  // latched byte must not follow the bus
  endtask

  initial begin
    int t, t1, t2;
    logic [9:0] a5_line;
    fork
      monitor();
    join_none

    // 1: reset held for cycles 0..2, released in cycle 3
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    at_cyc(3);
    chk("rst_ready_low", {31'd0, ready}, 32'd0);
    chk("rst_tx_idle", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    at_cyc(4);
    chk("ready_after_release", {31'd0, ready}, 32'd1);
    at_cyc(6);

    // 2: 0xA5, line 0,1,0,1,0,0,1,0,1 then stop
    a5_line = 10'b1101001010;
    send(8'hA5, t);
    for (int k = 0; k < 9; k++) begin
      at_cyc(t + 1 + CPB * k + 5);
      chk("a5_bit", {31'd0, tx}, {31'd0, a5_line[k]});
    end
    at_cyc(t + FRAME - 5);
    chk("a5_stop", {31'd0, tx}, 32'd1);
    at_cyc(t + FRAME);
    chk("a5_busy_last", {31'd0, busy}, 32'd1);
    chk("a5_ready_last", {31'd0, ready}, 32'd0);
    at_cyc(t + FRAME + 1);
    chk("a5_ready_back", {31'd0, ready}, 32'd1);
    chk("a5_busy_done", {31'd0, busy}, 32'd0);
    at_cyc(t + FRAME + 4);

    // 3: back-to-back 0x00 then 0xFF with data_valid held high
    data = 8'h00;
    data_valid = 1'b1;
    wait_acc(t1);
    data = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      at_cyc(t1 + 1 + CPB * k + 5);
      chk("b2b_00_bit", {31'd0, tx}, 32'd0);
    end
    wait_acc(t2);
    data_valid = 1'b0;
    chk("b2b_period", t2 - t1, (NPAR == 1) ? 32'd111 : 32'd101);
    at_cyc(t2 + 6);
    chk("b2b_ff_start", {31'd0, tx}, 32'd0);
    for (int k = 1; k < 9; k++) begin
      at_cyc(t2 + 1 + CPB * k + 5);
      chk("b2b_ff_bit", {31'd0, tx}, 32'd1);
    end
    at_cyc(t2 + FRAME + 3);

    // 4: reset pulse during data bit 3 of 0x3C, then a clean 0xC3
    send(8'h3C, t);
    at_cyc(t + 1 + CPB * 3 + 5);
    chk("3c_bit2", {31'd0, tx}, 32'd1);
    at_cyc(t + 45);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    at_cyc(t + 46);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    at_cyc(t + 47);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    send(8'hC3, t);
    at_cyc(t + 1 + CPB * 3 + 5);
    chk("c3_bit3", {31'd0, tx}, 32'd0);
    at_cyc(t + 1 + CPB * 8 + 5);
    chk("c3_bit8", {31'd0, tx}, 32'd1);
    at_cyc(t + FRAME + 3);

    // accept and reset in the same cycle: reset wins, byte dropped
    rst = 1'b1;
    data = 8'h81;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_valid = 1'b0;
    t = cyc;
    at_cyc(t + 3);
    chk("rst_accept_busy", {31'd0, busy}, 32'd0);
    chk("rst_accept_tx", {31'd0, tx}, 32'd1);

`ifdef UART_TX_PARITY_EN
    // 5: even parity of 0x07 is 1, frame 110 clks
    send(8'h07, t);
    at_cyc(t + 1 + CPB * 9 + 5);
    chk("par_07", {31'd0, tx}, 32'd1);
    at_cyc(t + 110);
    chk("par_busy_last", {31'd0, busy}, 32'd1);
    at_cyc(t + 111);
    chk("par_ready_back", {31'd0, ready}, 32'd1);
`endif

    repeat (5) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
